// File: rtl/word_pack.sv
// Serial-to-block packer: collects WORD_W-bit words into one WORDS-word block,
// word 0 in the most-significant slot, with early close (zero fill) and discard.
module word_pack #(
  parameter  int WORD_W  = 32,
  parameter  int WORDS   = 16,
  localparam int BLOCK_W = WORD_W * WORDS,
  localparam int CNT_W   = $clog2(WORDS) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] block,
  output logic               block_valid,
  input  logic               block_ready,
  output logic [CNT_W-1:0]   block_words,
  output logic [CNT_W-1:0]   fill_count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0]   fill_count_q, fill_count_d;
  logic [CNT_W-1:0]   block_words_q, block_words_d;
  int                 lsb;

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    block_d       = block_q;
    fill_count_d  = fill_count_q;
    block_words_d = block_words_q;
    lsb           = (WORDS - 1 - int'(fill_count_q)) * WORD_W;

    if (clear) begin
      state_d       = FILL;
      block_d       = '0;
      fill_count_d  = '0;
      block_words_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            block_d[lsb +: WORD_W] = in_data;
            if (in_last || fill_count_q == LAST_SLOT) begin
              state_d       = HOLD;
              block_words_d = fill_count_q + 1'b1;
              fill_count_d  = '0;
            end else begin
              fill_count_d = fill_count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Zeroing on release is what provides the zero fill after an early close.
          if (block_ready) begin
            state_d       = FILL;
            block_d       = '0;
            block_words_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: the block register is reset along with the control state, since
  // unwritten slots must read as zero after an early close.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all registers updating from the same
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= FILL;
      block_q       <= '0;
      fill_count_q  <= '0;
      block_words_q <= '0;
    end else begin
      state_q       <= state_d;
      block_q       <= block_d;
      fill_count_q  <= fill_count_d;
      block_words_q <= block_words_d;
    end
  end

  assign in_ready    = (state_q == FILL);
  assign block_valid = (state_q == HOLD);
  assign block       = block_q;
  assign block_words = block_words_q;
  assign fill_count  = fill_count_q;

endmodule
